gray_count_scheduler: RTL and testbench
=======================================

// Module: gray_count_scheduler
// PURPOSE
//  Shares one free-running WIDTH-bit Gray-code counter among NREQ requesters.
//  Each requester asks for a burst of req_len consecutive Gray values. Grants are
//  round-robin, and a burst is never preempted. The block sits in front of the
//  counter datapath and is the only agent that advances it.
// PARAMETERS
//  WIDTH   3  counter width; the counter wraps modulo 2^WIDTH
//  NREQ    4  number of requesters (>=2)
//  LEN_W   4  width of each burst-length field
//  IDW     derived localparam, $clog2(NREQ); width of the owner id
// PORTS
//  clk         in   1           rising-edge clock; the only clock
//  reset       in   1           synchronous, active-high reset
//  req         in   NREQ        per-requester request level; sampled only in IDLE
//  req_len     in   NREQ*LEN_W  burst length; requester i uses [i*LEN_W +: LEN_W]
//  enable      in   1           advance qualifier; low = stall the burst in place
//  gnt         out  NREQ        one-hot grant, held for the whole burst
//  cnt_owner   out  IDW         index of the current or most recent grantee
//  cnt_valid   out  1           cnt_gray carries a newly issued value this cycle
//  cnt_gray    out  WIDTH       Gray value issued: bin ^ (bin >> 1)
//  burst_done  out  1           one-cycle pulse on the final cycle of a burst
// BEHAVIOUR
//  Reset and state
//  - All outputs are registered.
//  - Reset clears gnt, cnt_owner, cnt_valid, cnt_gray, burst_done, the internal
//    binary counter bin and the remaining count rem. The RR pointer ptr goes to 0
//    and the FSM goes to IDLE.
//  - Reset wins over any other event, including mid-burst. An aborted burst issues
//    no burst_done.
//  - FSM states: IDLE, RUN.
//  IDLE
//  - If req is nonzero, grant the first set bit scanning ptr, ptr+1, ... (mod NREQ).
//  - On that edge: gnt <= onehot(winner), cnt_owner <= winner, rem <= that
//    requester's req_len, state <= RUN.
//  - If req is zero, stay in IDLE. All pulses stay low.
//  RUN
//  - rem==0 (zero-length request): on the next edge, gnt <= 0, burst_done <= 1,
//    ptr <= owner+1, state <= IDLE. No cnt_valid is issued and bin is unchanged.
//    This applies regardless of enable.
//  - enable=1, rem>0: on each edge, cnt_valid <= 1, cnt_gray <= bin ^ (bin >> 1),
//    bin <= bin+1 (mod 2^WIDTH), rem <= rem-1.
//  - If that issue has rem==1, then in the same edge: burst_done <= 1, gnt <= 0,
//    ptr <= owner+1 (mod NREQ), state <= IDLE.
//  - enable=0: no issue. cnt_valid stays 0; bin, rem, gnt and state hold.
//  Timing and sharing
//  - cnt_valid and burst_done are pulses, cleared every cycle unless re-set.
//  - cnt_gray holds its last value between issues.
//  - gnt rises 1 cycle after req is sampled. The first cnt_valid follows 1 cycle
//    after gnt rises.
//  - The last cnt_valid, burst_done and gnt deassertion all fall in the same cycle.
//  - There is one mandatory IDLE bubble cycle between consecutive bursts.
//  - bin is shared and never rewinds between owners: each new burst continues the
//    Gray sequence where the previous burst stopped, including across wrap.
//  - Deasserting req, or changing req_len, during RUN has no effect. The burst
//    runs to completion.
//  - A requester still asserting req after its burst is eligible again, at lowest
//    priority.
//  - Adjacent issued cnt_gray values always differ in exactly one bit, including
//    the 2^WIDTH-1 -> 0 wrap.
// TESTING
//  - Reset, with random inputs held for 3 cycles -> gnt=0, cnt_valid=0,
//    burst_done=0, cnt_gray=000, cnt_owner=0.
//  - Only req[1], len=3, enable=1, from reset -> gnt=0010 at cycle 1.
//    cnt_valid at cycles 2-4 with cnt_gray 000, 001, 011. burst_done and gnt=0
//    at cycle 4.
//  - req=1111, all len=1, held -> owners 0,1,2,3,0 with one bubble cycle between.
//    cnt_gray continues 000, 001, 011, 010, 110.
//  - Single req, len=10, WIDTH=3 -> cnt_gray 000, 001, 011, 010, 110, 111, 101,
//    100, 000, 001. Each step is a 1-bit change.
//  - len=4 with enable toggling 1,0,0,1,... -> no cnt_valid while enable is low.
//    gnt stays held, and exactly 4 issues occur before burst_done.
//  - Reset asserted at the 2nd issue of a len=5 burst -> all outputs 0 next cycle
//    with no burst_done. A len=0 request then yields a 1-cycle gnt, burst_done,
//    and no cnt_valid.

Source files
------------

// File: rtl/gray_count_scheduler.sv
// gray_count_scheduler
//   Shares one free-running WIDTH-bit Gray-code counter among NREQ requesters.
//   A requester wins a round-robin grant and then receives a burst of req_len
//   consecutive Gray values. A burst is never preempted. The binary counter
//   behind the Gray output is shared, so every burst continues the sequence
//   where the previous one stopped.
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   req         in   per-requester request level, sampled only while idle
//   req_len     in   packed burst lengths, requester i uses [i*LEN_W +: LEN_W]
//   enable      in   advance qualifier, low stalls the burst in place
//   gnt         out  one-hot grant, held for the whole burst
//   cnt_owner   out  index of the current or most recent grantee
//   cnt_valid   out  cnt_gray carries a newly issued value this cycle
//   cnt_gray    out  Gray value issued (bin ^ (bin >> 1)), held between issues
//   burst_done  out  one-cycle pulse on the final cycle of a burst
module gray_count_scheduler #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned LEN_W = 4,
    localparam int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*LEN_W-1:0] req_len,
    input  logic                  enable,
    output logic [NREQ-1:0]       gnt,
    output logic [IDW-1:0]        cnt_owner,
    output logic                  cnt_valid,
    output logic [WIDTH-1:0]      cnt_gray,
    output logic                  burst_done
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e             state_q, state_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [IDW-1:0]     owner_q, owner_d;
    logic               valid_q, valid_d;
    logic [WIDTH-1:0]   gray_q, gray_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   bin_q, bin_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [IDW-1:0]     ptr_q, ptr_d;

    // Round-robin search: first set request bit starting at ptr, wrapping mod NREQ.
    logic [IDW-1:0]     win_idx;
    logic               win_found;
    logic [LEN_W-1:0]   win_len;
    int unsigned        cand;
    logic [IDW-1:0]     cand_idx;

    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = 32'(ptr_q) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_idx = cand[IDW-1:0];
            if (!win_found && req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    assign win_len = req_len[win_idx*LEN_W +: LEN_W];

    // Pointer moves just past the finishing owner so it drops to lowest priority.
    logic [IDW-1:0] owner_next;
    assign owner_next = (owner_q == IDW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        valid_d = 1'b0;
        gray_d  = gray_q;
        done_d  = 1'b0;
        bin_d   = bin_q;
        rem_d   = rem_q;
        ptr_d   = ptr_q;

        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    owner_d        = win_idx;
                    rem_d          = win_len;
                    state_d        = StRun;
                end
            end
            StRun: begin
                if (rem_q == '0) begin
                    // Zero-length burst: close out without issuing, regardless of enable.
                    gnt_d   = '0;
                    done_d  = 1'b1;
                    ptr_d   = owner_next;
                    state_d = StIdle;
                end else if (enable) begin
                    valid_d = 1'b1;
                    gray_d  = bin_q ^ (bin_q >> 1);
                    bin_d   = bin_q + 1'b1;
                    rem_d   = rem_q - 1'b1;
                    if (rem_q == LEN_W'(1)) begin
                        gnt_d   = '0;
                        done_d  = 1'b1;
                        ptr_d   = owner_next;
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            owner_q <= '0;
            valid_q <= 1'b0;
            gray_q  <= '0;
            done_q  <= 1'b0;
            bin_q   <= '0;
            rem_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            valid_q <= valid_d;
            gray_q  <= gray_d;
            done_q  <= done_d;
            bin_q   <= bin_d;
            rem_q   <= rem_d;
            ptr_q   <= ptr_d;
        end
    end

    assign gnt        = gnt_q;
    assign cnt_owner  = owner_q;
    assign cnt_valid  = valid_q;
    assign cnt_gray   = gray_q;
    assign burst_done = done_q;

endmodule

// File: tb/tb_gray_count_scheduler.sv
// Self-checking bench for gray_count_scheduler: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a model.
module tb_gray_count_scheduler;

    localparam int unsigned WIDTH = 3;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned LEN_W = 4;
    localparam int unsigned IDW   = 2;

    logic                  clk;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*LEN_W-1:0] req_len;
    logic                  enable;
    logic [NREQ-1:0]       gnt;
    logic [IDW-1:0]        cnt_owner;
    logic                  cnt_valid;
    logic [WIDTH-1:0]      cnt_gray;
    logic                  burst_done;

    int vectors     = 0;
    int miscompares = 0;

    gray_count_scheduler #(
        .WIDTH (WIDTH),
        .NREQ  (NREQ),
        .LEN_W (LEN_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_len    (req_len),
        .enable     (enable),
        .gnt        (gnt),
        .cnt_owner  (cnt_owner),
        .cnt_valid  (cnt_valid),
        .cnt_gray   (cnt_gray),
        .burst_done (burst_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %0h, expected %0h, t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit              m_busy;
    int              m_owner;
    int              m_left;
    int              m_ptr;
    int              m_issued;      // total values issued since reset
    logic [NREQ-1:0] m_gnt;
    logic            m_valid;
    logic            m_done;
    int              m_gray;
    bit              m_rst_seen;
    bit              have_prev;
    logic [WIDTH-1:0] prev_gray;

    function automatic int gray_of(input int b);
        return b ^ (b >> 1);
    endfunction

    task automatic model_finish();
        m_gnt  = '0;
        m_done = 1'b1;
        m_busy = 1'b0;
        m_ptr  = (m_owner + 1) % NREQ;
    endtask

    task automatic model_step();
        m_rst_seen = reset;
        if (reset) begin
            m_busy = 0; m_owner = 0; m_left = 0; m_ptr = 0; m_issued = 0;
            m_gnt = '0; m_valid = 0; m_done = 0; m_gray = 0;
        end else begin
            m_valid = 0;
            m_done  = 0;
            if (!m_busy) begin
                bit found = 0;
                int winner = 0;
                for (int k = 0; k < NREQ; k++) begin
                    int c = (m_ptr + k) % NREQ;
                    if (!found && req[c]) begin
                        found  = 1;
                        winner = c;
                    end
                end
                if (found) begin
                    m_busy  = 1;
                    m_owner = winner;
                    m_gnt   = '0;
                    m_gnt[winner] = 1'b1;
                    m_left  = int'(req_len[winner*LEN_W +: LEN_W]);
                end
            end else if (m_left == 0) begin
                model_finish();
            end else if (enable) begin
                m_valid = 1;
                m_gray  = gray_of(m_issued % (1 << WIDTH));
                m_issued++;
                m_left--;
                if (m_left == 0) model_finish();
            end
        end
    endtask

    // Every-cycle compare against the model, plus the one-bit-step property.
    always @(posedge clk) begin
        model_step();
        #1;
        check("gnt", 32'(gnt), 32'(m_gnt));
        check("cnt_owner", 32'(cnt_owner), m_owner);
        check("cnt_valid", 32'(cnt_valid), 32'(m_valid));
        check("cnt_gray", 32'(cnt_gray), m_gray);
        check("burst_done", 32'(burst_done), 32'(m_done));
        if (m_rst_seen) begin
            have_prev = 0;
        end else if (cnt_valid) begin
            if (have_prev) check("gray_step_bits", $countones(prev_gray ^ cnt_gray), 1);
            prev_gray = cnt_gray;
            have_prev = 1;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_len(input int i, input int v);
        req_len[i*LEN_W +: LEN_W] = LEN_W'(v);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    int exp5[5]   = '{0, 1, 3, 2, 6};
    int exp10[10] = '{0, 1, 3, 2, 6, 7, 5, 4, 0, 1};

    initial begin
        reset   = 1'b1;
        req     = NREQ'($urandom);
        req_len = ($urandom);
        enable  = 1'($urandom);

        // Reset held 3 cycles with random inputs.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_gnt", 32'(gnt), 0);
            check("rst_valid", 32'(cnt_valid), 0);
            check("rst_done", 32'(burst_done), 0);
            check("rst_gray", 32'(cnt_gray), 0);
            check("rst_owner", 32'(cnt_owner), 0);
            req     = NREQ'($urandom);
            req_len = ($urandom);
            enable  = 1'($urandom);
        end

        // Single requester 1, len 3.
        reset = 1'b0; req = 4'b0010; req_len = '0; set_len(1, 3); enable = 1'b1;
        tick();
        check("t2_gnt_c1", 32'(gnt), 32'b0010);
        check("t2_valid_c1", 32'(cnt_valid), 0);
        req = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_valid", 32'(cnt_valid), 1);
            check("t2_gray", 32'(cnt_gray), exp5[i]);
            check("t2_done", 32'(burst_done), (i == 2) ? 1 : 0);
            check("t2_gnt", 32'(gnt), (i == 2) ? 0 : 32'b0010);
        end
        tick();

        // All requesting, len 1 each: round-robin with a bubble between bursts.
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < NREQ; i++) set_len(i, 1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t3_owner", 32'(cnt_owner), k % NREQ);
            check("t3_gnt", 32'(gnt), 1 << (k % NREQ));
            check("t3_bubble_valid", 32'(cnt_valid), 0);
            tick();
            check("t3_valid", 32'(cnt_valid), 1);
            check("t3_gray", 32'(cnt_gray), exp5[k]);
            check("t3_done", 32'(burst_done), 1);
        end
        req = '0;
        tick();

        // Len 10 through the 3-bit wrap.
        do_reset();
        req = 4'b0001; set_len(0, 10);
        tick();
        req = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t4_valid", 32'(cnt_valid), 1);
            check("t4_gray", 32'(cnt_gray), exp10[i]);
            check("t4_done", 32'(burst_done), (i == 9) ? 1 : 0);
        end
        tick();

        // Enable toggling 1,0,0,... on a len-4 burst.
        begin
            int  issues = 0;
            bit  seen_done = 0;
            int  cyc = 0;
            req = 4'b0100; set_len(2, 4);
            tick();
            req = '0;
            while (!seen_done && cyc < 40) begin
                bit en = (cyc % 3 == 0);
                enable = en;
                tick();
                if (!en) check("t5_stall_valid", 32'(cnt_valid), 0);
                if (cnt_valid) issues++;
                if (burst_done) seen_done = 1;
                else check("t5_gnt_held", 32'(gnt), 32'b0100);
                cyc++;
            end
            check("t5_done_seen", 32'(seen_done), 1);
            check("t5_issues", issues, 4);
            enable = 1'b1;
            tick();
        end

        // Reset in the middle of a len-5 burst, then a len-0 request.
        do_reset();
        req = 4'b1000; set_len(3, 5);
        tick();
        req = '0;
        tick();
        check("t6_first_issue", 32'(cnt_valid), 1);
        reset = 1'b1;
        tick();
        check("t6_abort_gnt", 32'(gnt), 0);
        check("t6_abort_valid", 32'(cnt_valid), 0);
        check("t6_abort_done", 32'(burst_done), 0);
        check("t6_abort_gray", 32'(cnt_gray), 0);
        check("t6_abort_owner", 32'(cnt_owner), 0);
        reset = 1'b0; req = 4'b0001; set_len(0, 0);
        tick();
        check("t6_len0_gnt", 32'(gnt), 32'b0001);
        req = '0;
        tick();
        check("t6_len0_gnt_off", 32'(gnt), 0);
        check("t6_len0_done", 32'(burst_done), 1);
        check("t6_len0_valid", 32'(cnt_valid), 0);
        tick();
        check("t6_len0_done_pulse", 32'(burst_done), 0);

        // Randomized traffic; the per-cycle compare does the checking.
        for (int i = 0; i < 3000; i++) begin
            reset   = ($urandom_range(0, 199) == 0);
            req     = ($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom);
            req_len = ($urandom);
            if ($urandom_range(0, 1) == 1) begin
                for (int j = 0; j < NREQ; j++) set_len(j, $urandom_range(0, 3));
            end
            enable  = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
